pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum cycles a memory handshake may remain unanswered before the sequencer faults (legal range 1..255).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr  input  16  current instruction register contents; opcode = instr[15:12].
REQ-005 cond_met  input  1  branch condition evaluated externally from flags; sampled only in EXECUTE.
REQ-006 mem_ready  input  1  memory handshake acknowledge for the current mem_rd/mem_wr request.
REQ-007 pc_en  output  1  program counter load enable, one-cycle pulse.
REQ-008 pc_sel  output  2  PC source: 2'b00 PC+1, 2'b01 PC+branch offset, 2'b10 jump target; 2'b00 whenever pc_en=0.
REQ-009 ir_load  output  1  instruction register load strobe.
REQ-010 mem_rd, mem_wr  output  1 each  memory read/write request, held until acknowledged.
REQ-011 addr_sel  output  1  memory address source: 0 = PC, 1 = data address.
REQ-012 rf_we  output  1  register-file write enable, one-cycle pulse.
REQ-013 state  output  3  current state encoding; halted, fault  output  1 each  status flags.

Function
REQ-014 States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5, FAULT=6; the state is a single registered variable; code 7 returns to FETCH on the next edge.
REQ-015 Outputs are combinational from the state register, instr, cond_met and mem_ready; every output is 0 in any state/condition not listed below.
REQ-016 FETCH: mem_rd=1, addr_sel=0; on mem_ready=1, ir_load=1 in the same cycle and next state DECODE; otherwise remain in FETCH.
REQ-017 DECODE: no outputs asserted; next state EXECUTE unconditionally (one-cycle decode latency).
REQ-018 EXECUTE, opcode 0x0-0x3 (ALU): rf_we=1, pc_en=1, pc_sel=00; next FETCH.
REQ-019 EXECUTE, opcode 0x4 (LOAD) or 0x5 (STORE): no strobes; next MEM.
REQ-020 EXECUTE, opcode 0x6 (BRANCH): pc_en=1, pc_sel=01 if cond_met=1 else 00; next FETCH.
REQ-021 EXECUTE, opcode 0x7 (JUMP): pc_en=1, pc_sel=10; next FETCH.
REQ-022 EXECUTE, opcode 0xF (HALT): no strobes; next HALT; all other opcodes are NOP: pc_en=1, pc_sel=00; next FETCH.
REQ-023 MEM: addr_sel=1; mem_rd=1 for LOAD, mem_wr=1 for STORE; on mem_ready=1 a STORE pulses pc_en (pc_sel=00) and goes to FETCH, a LOAD goes to WB.
REQ-024 WB: rf_we=1, pc_en=1, pc_sel=00; next FETCH.
REQ-025 HALT: halted=1, no other outputs; remain until reset.
REQ-026 An 8-bit wait counter clears on entry to FETCH or MEM and increments each cycle spent there with mem_ready=0.
REQ-027 If mem_ready=0 while the wait counter equals WAIT_MAX-1, the next state is FAULT; mem_ready=1 in that same cycle completes normally.
REQ-028 FAULT: fault=1, no other outputs; sticky until reset; mem_ready ignored.
REQ-029 Instruction latency: ALU/BRANCH/JUMP = fetch wait + 3 cycles; STORE = fetch wait + mem wait + 4; LOAD = fetch wait + mem wait + 5.

Reset
REQ-030 reset=1 at a rising edge forces state=FETCH, clears the wait counter, halted=0, fault=0; it overrides every transition, including from HALT, FAULT or mid-handshake.
REQ-031 During the reset cycle the outputs follow the pre-edge state; from the first edge after reset, outputs match FETCH (mem_rd=1, all others 0).

Configuration
REQ-032 Macro PC_SEQ_STEP_EN: when defined, an input step (1 bit) is added and a step_armed flag is set on any edge with step=1; FETCH drives mem_rd=0 and freezes the wait counter until step_armed=1; step_armed clears on ir_load; reset clears step_armed.
REQ-033 Without PC_SEQ_STEP_EN the step port does not exist and FETCH behaves as if step_armed=1 always.

Verification
REQ-034 Reset, then instr=0x1234, mem_ready=1 in FETCH -> ir_load at cycle 1, rf_we and pc_en (pc_sel=00) at cycle 3, back in FETCH at cycle 4.
REQ-035 instr=0x6000, cond_met=1 then repeat with cond_met=0 -> pc_en with pc_sel=01 then pc_sel=00 in EXECUTE.
REQ-036 instr=0x4000 (LOAD), mem_ready held low 3 cycles in MEM -> mem_rd=1, addr_sel=1 for 4 cycles, then WB with rf_we=1 and pc_en=1.
REQ-037 WAIT_MAX=15, mem_ready=0 in FETCH -> state=FAULT after exactly 15 FETCH cycles, fault=1; reset -> state=0, fault=0.
REQ-038 instr=0xF000 -> halted=1 and no pc_en for 20 cycles; reset asserted mid-MEM of a STORE -> FETCH next cycle with mem_wr=0.
REQ-039 With PC_SEQ_STEP_EN, step=0 -> mem_rd stays 0 for 10 cycles and no fault; one step pulse -> exactly one instruction fetched.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle control sequencer for a 16-bit accumulator-style core.
//
// Walks each instruction through FETCH -> DECODE -> EXECUTE [-> MEM [-> WB]]. It drives
// the program-counter, instruction-register, memory-handshake and register-file strobes.
// A per-handshake wait counter moves the sequencer to a sticky FAULT state when memory
// stays silent for too long.
//
// Parameters
//   WAIT_MAX   cycles a memory handshake may remain unanswered before FAULT (1..255)
//
// Optional feature (macro PC_SEQ_STEP_EN)
//   Adds input 'step'. FETCH only issues its read once a step pulse has armed it, and
//   each step pulse lets exactly one instruction through. Without the macro, FETCH is
//   always armed.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high reset
//   step       in   single-step request (only with PC_SEQ_STEP_EN)
//   instr      in   [15:0] instruction register contents, opcode = instr[15:12]
//   cond_met   in   branch condition, only looked at in EXECUTE
//   mem_ready  in   memory handshake acknowledge
//   pc_en      out  program counter load enable (one-cycle pulse)
//   pc_sel     out  [1:0] PC source: 00 PC+1, 01 PC+offset, 10 jump target
//   ir_load    out  instruction register load strobe
//   mem_rd     out  memory read request, held until acknowledged
//   mem_wr     out  memory write request, held until acknowledged
//   addr_sel   out  memory address source: 0 = PC, 1 = data address
//   rf_we      out  register-file write enable (one-cycle pulse)
//   state      out  [2:0] current state encoding
//   halted     out  HALT state flag
//   fault      out  FAULT state flag
module pc_sequencer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
`ifdef PC_SEQ_STEP_EN
  input  logic        step,
`endif
  input  logic [15:0] instr,
  input  logic        cond_met,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        ir_load,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        addr_sel,
  output logic        rf_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StExecute = 3'd2,
    StMem     = 3'd3,
    StWb      = 3'd4,
    StHalt    = 3'd5,
    StFault   = 3'd6
  } state_e;

  localparam logic [3:0] OpLoad   = 4'h4;
  localparam logic [3:0] OpStore  = 4'h5;
  localparam logic [3:0] OpBranch = 4'h6;
  localparam logic [3:0] OpJump   = 4'h7;
  localparam logic [3:0] OpHalt   = 4'hF;

  localparam logic [1:0] PcInc    = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  // Last wait count at which an unanswered handshake is still tolerated.
  localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [3:0]  opcode;
  logic        wait_expired;
  logic        fetch_go;

  // Only the opcode field is decoded here; operands belong to the datapath.
  logic        unused_instr;
  assign unused_instr = ^instr[11:0];

  assign opcode       = instr[15:12];
  assign wait_expired = (wait_q == WaitLast);

  //--------------------------------------------------------------------------
  // Single-step gate
  //--------------------------------------------------------------------------
`ifdef PC_SEQ_STEP_EN
  logic step_armed_q, step_armed_d;

  // A step pulse that coincides with ir_load re-arms, so a held step free-runs.
  always_comb begin
    step_armed_d = step | (step_armed_q & ~ir_load);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_armed_q <= 1'b0;
    end else begin
      step_armed_q <= step_armed_d;
    end
  end

  assign fetch_go = step_armed_q;
`else
  assign fetch_go = 1'b1;
`endif

  //--------------------------------------------------------------------------
  // State register and wait counter
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  //--------------------------------------------------------------------------
  // Next state and decoded outputs
  //--------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pc_en    = 1'b0;
    pc_sel   = PcInc;
    ir_load  = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    addr_sel = 1'b0;
    rf_we    = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;

    case (state_q)
      StFetch: begin
        // An unarmed fetch issues nothing and cannot time out.
        if (fetch_go) begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            ir_load = 1'b1;
            state_d = StDecode;
          end else if (wait_expired) begin
            state_d = StFault;
          end
        end
      end

      StDecode: begin
        state_d = StExecute;
      end

      StExecute: begin
        case (opcode)
          4'h0, 4'h1, 4'h2, 4'h3: begin
            rf_we   = 1'b1;
            pc_en   = 1'b1;
            state_d = StFetch;
          end
          OpLoad, OpStore: begin
            state_d = StMem;
          end
          OpBranch: begin
            pc_en   = 1'b1;
            pc_sel  = cond_met ? PcBranch : PcInc;
            state_d = StFetch;
          end
          OpJump: begin
            pc_en   = 1'b1;
            pc_sel  = PcJump;
            state_d = StFetch;
          end
          OpHalt: begin
            state_d = StHalt;
          end
          default: begin
            pc_en   = 1'b1;
            state_d = StFetch;
          end
        endcase
      end

      StMem: begin
        if (opcode == OpStore) begin
          addr_sel = 1'b1;
          mem_wr   = 1'b1;
          if (mem_ready) begin
            pc_en   = 1'b1;
            state_d = StFetch;
          end else if (wait_expired) begin
            state_d = StFault;
          end
        end else if (opcode == OpLoad) begin
          addr_sel = 1'b1;
          mem_rd   = 1'b1;
          if (mem_ready) begin
            state_d = StWb;
          end else if (wait_expired) begin
            state_d = StFault;
          end
        end else begin
          // instr changed under a pending access; abandon it and refetch.
          state_d = StFetch;
        end
      end

      StWb: begin
        rf_we   = 1'b1;
        pc_en   = 1'b1;
        state_d = StFetch;
      end

      StHalt: begin
        halted = 1'b1;
      end

      StFault: begin
        fault = 1'b1;
      end

      default: begin
        // Unused encoding 7 recovers to FETCH.
        state_d = StFetch;
      end
    endcase
  end

  // The counter restarts on every state change, so it is zero whenever FETCH or MEM is
  // entered. It only runs while a handshake is actually outstanding.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if (((state_q == StFetch) && fetch_go) || (state_q == StMem)) begin
      if (!mem_ready) begin
        wait_d = wait_q + 8'd1;
      end
    end
  end

  assign state = state_q;

  //--------------------------------------------------------------------------
  // Structural invariants
  //--------------------------------------------------------------------------
  a_pc_sel_idle: assert property (@(posedge clk) disable iff (reset)
    !pc_en |-> (pc_sel == PcInc));

  a_rd_wr_excl: assert property (@(posedge clk) disable iff (reset)
    !(mem_rd && mem_wr));

  a_fault_sticky: assert property (@(posedge clk) disable iff (reset)
    (state_q == StFault) |=> (state_q == StFault));

  a_halt_sticky: assert property (@(posedge clk) disable iff (reset)
    (state_q == StHalt) |=> (state_q == StHalt));

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (default build, WAIT_MAX = 15).
// Each vector drives one cycle's inputs; the expected state/outputs are queued when the
// vector is driven and popped and compared once the combinational outputs have settled.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        cond_met;
  logic        mem_ready;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic        ir_load;
  logic        mem_rd;
  logic        mem_wr;
  logic        addr_sel;
  logic        rf_we;
  logic [2:0]  state;
  logic        halted;
  logic        fault;
`ifdef PC_SEQ_STEP_EN
  logic        step = 1'b1;
`endif

  always #5 clk = ~clk;

  pc_sequencer #(
    .WAIT_MAX(15)
  ) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef PC_SEQ_STEP_EN
    .step     (step),
`endif
    .instr    (instr),
    .cond_met (cond_met),
    .mem_ready(mem_ready),
    .pc_en    (pc_en),
    .pc_sel   (pc_sel),
    .ir_load  (ir_load),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .addr_sel (addr_sel),
    .rf_we    (rf_we),
    .state    (state),
    .halted   (halted),
    .fault    (fault)
  );

  // Output bundle order: {pc_en, pc_sel[1:0], ir_load, mem_rd, mem_wr, addr_sel, rf_we,
  //                       halted, fault}
  localparam logic [9:0] O_NONE = 10'b0_00_0_0_0_0_0_0_0;
  localparam logic [9:0] O_FW   = 10'b0_00_0_1_0_0_0_0_0;
  localparam logic [9:0] O_FR   = 10'b0_00_1_1_0_0_0_0_0;
  localparam logic [9:0] O_ALU  = 10'b1_00_0_0_0_0_1_0_0;
  localparam logic [9:0] O_PC1  = 10'b1_00_0_0_0_0_0_0_0;
  localparam logic [9:0] O_BRT  = 10'b1_01_0_0_0_0_0_0_0;
  localparam logic [9:0] O_JMP  = 10'b1_10_0_0_0_0_0_0_0;
  localparam logic [9:0] O_LD   = 10'b0_00_0_1_0_1_0_0_0;
  localparam logic [9:0] O_STW  = 10'b0_00_0_0_1_1_0_0_0;
  localparam logic [9:0] O_STR  = 10'b1_00_0_0_1_1_0_0_0;
  localparam logic [9:0] O_WB   = 10'b1_00_0_0_0_0_1_0_0;
  localparam logic [9:0] O_HLT  = 10'b0_00_0_0_0_0_0_1_0;
  localparam logic [9:0] O_FLT  = 10'b0_00_0_0_0_0_0_0_1;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3;
  localparam logic [2:0] S_W = 3'd4, S_H = 3'd5, S_X = 3'd6;

  typedef struct packed {
    logic        rst;
    logic [15:0] instr;
    logic        cond;
    logic        rdy;
    logic [2:0]  st;
    logic [9:0]  out;
  } vec_t;

  typedef struct packed {
    logic [2:0] st;
    logic [9:0] out;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   seq_idx = 0;

  task automatic add(input logic rst, input logic [15:0] ins, input logic cond,
                     input logic rdy, input logic [2:0] st, input logic [9:0] out);
    vec_t v;
    v = '{rst: rst, instr: ins, cond: cond, rdy: rdy, st: st, out: out};
    tbl.push_back(v);
  endtask

  task automatic check_head(input string tag, input int idx);
    exp_t       e;
    logic [9:0] got;
    got = {pc_en, pc_sel, ir_load, mem_rd, mem_wr, addr_sel, rf_we, halted, fault};
    e   = exp_q.pop_front();
    checks++;
    if (state !== e.st || got !== e.out) begin
      errors++;
      $display("FAIL %s[%0d]: got state=%0d outs=%b, expected state=%0d outs=%b",
               tag, idx, state, got, e.st, e.out);
    end
  endtask

  task automatic apply(input vec_t v, input string tag, input int idx);
    exp_t e;
    @(negedge clk);
    reset     = v.rst;
    instr     = v.instr;
    cond_met  = v.cond;
    mem_ready = v.rdy;
    e = '{st: v.st, out: v.out};
    exp_q.push_back(e);
    #1;
    check_head(tag, idx);
  endtask

  task automatic step_seq(input string tag, input logic rst, input logic [15:0] ins,
                          input logic cond, input logic rdy, input logic [2:0] st,
                          input logic [9:0] out);
    vec_t v;
    v = '{rst: rst, instr: ins, cond: cond, rdy: rdy, st: st, out: out};
    apply(v, tag, seq_idx);
    seq_idx++;
  endtask

  initial begin
    reset     = 1'b1;
    instr     = 16'h0000;
    cond_met  = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then the main instruction classes back to back.
    add(1, 16'h0000, 0, 0, S_F, O_FW);
    add(0, 16'h1234, 0, 1, S_F, O_FR);   // ALU: ir_load at first cycle
    add(0, 16'h1234, 0, 0, S_D, O_NONE);
    add(0, 16'h1234, 0, 0, S_E, O_ALU);
    add(0, 16'h6000, 1, 1, S_F, O_FR);   // branch taken
    add(0, 16'h6000, 1, 0, S_D, O_NONE);
    add(0, 16'h6000, 1, 0, S_E, O_BRT);
    add(0, 16'h6000, 0, 1, S_F, O_FR);   // branch not taken
    add(0, 16'h6000, 0, 0, S_D, O_NONE);
    add(0, 16'h6000, 0, 0, S_E, O_PC1);
    add(0, 16'h7ABC, 1, 1, S_F, O_FR);   // jump
    add(0, 16'h7ABC, 1, 0, S_D, O_NONE);
    add(0, 16'h7ABC, 1, 0, S_E, O_JMP);
    add(0, 16'h4000, 0, 0, S_F, O_FW);   // load, one fetch wait
    add(0, 16'h4000, 0, 1, S_F, O_FR);
    add(0, 16'h4000, 0, 0, S_D, O_NONE);
    add(0, 16'h4000, 0, 0, S_E, O_NONE);
    add(0, 16'h4000, 0, 0, S_M, O_LD);
    add(0, 16'h4000, 0, 0, S_M, O_LD);
    add(0, 16'h4000, 0, 0, S_M, O_LD);
    add(0, 16'h4000, 0, 1, S_M, O_LD);
    add(0, 16'h4000, 0, 0, S_W, O_WB);
    add(0, 16'h5000, 0, 1, S_F, O_FR);   // store, one mem wait
    add(0, 16'h5000, 0, 0, S_D, O_NONE);
    add(0, 16'h5000, 0, 0, S_E, O_NONE);
    add(0, 16'h5000, 0, 0, S_M, O_STW);
    add(0, 16'h5000, 0, 1, S_M, O_STR);
    add(0, 16'h8000, 0, 1, S_F, O_FR);   // undefined opcode acts as NOP
    add(0, 16'h8000, 0, 0, S_D, O_NONE);
    add(0, 16'h8000, 0, 0, S_E, O_PC1);
    add(0, 16'hF000, 0, 1, S_F, O_FR);   // halt
    add(0, 16'hF000, 0, 0, S_D, O_NONE);
    add(0, 16'hF000, 0, 0, S_E, O_NONE);
    add(0, 16'hF000, 0, 1, S_H, O_HLT);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], "vec", i);
    end

    // Halt holds for 20 cycles with no pc_en, whatever mem_ready does.
    for (int i = 0; i < 20; i++) begin
      step_seq("halt_hold", 0, 16'hF000, 1, logic'(i % 2), S_H, O_HLT);
    end
    step_seq("halt_reset", 1, 16'h5000, 0, 0, S_H, O_HLT);

    // Reset in the middle of a store's memory phase.
    step_seq("st_fetch", 0, 16'h5000, 0, 1, S_F, O_FR);
    step_seq("st_dec", 0, 16'h5000, 0, 0, S_D, O_NONE);
    step_seq("st_exe", 0, 16'h5000, 0, 0, S_E, O_NONE);
    step_seq("st_mem", 0, 16'h5000, 0, 0, S_M, O_STW);
    step_seq("st_mem_rst", 1, 16'h5000, 0, 0, S_M, O_STW);
    step_seq("st_after_rst", 0, 16'h5000, 0, 0, S_F, O_FW);

    // Fetch timeout: 15 unanswered FETCH cycles, then sticky FAULT.
    step_seq("ft_rst", 1, 16'h0000, 0, 0, S_F, O_FW);
    for (int i = 0; i < 15; i++) begin
      step_seq("ft_wait", 0, 16'h0000, 0, 0, S_F, O_FW);
    end
    for (int i = 0; i < 3; i++) begin
      step_seq("ft_fault", 0, 16'h0000, 0, 1, S_X, O_FLT);
    end
    step_seq("ft_fault_rst", 1, 16'h0000, 0, 0, S_X, O_FLT);

    // Ready on the last tolerated FETCH cycle completes normally.
    for (int i = 0; i < 14; i++) begin
      step_seq("bnd_wait", 0, 16'h4000, 0, 0, S_F, O_FW);
    end
    step_seq("bnd_ready", 0, 16'h4000, 0, 1, S_F, O_FR);
    step_seq("bnd_dec", 0, 16'h4000, 0, 0, S_D, O_NONE);
    step_seq("bnd_exe", 0, 16'h4000, 0, 0, S_E, O_NONE);

    // Wait counter restarts on MEM entry, then times out after 15 MEM cycles.
    for (int i = 0; i < 15; i++) begin
      step_seq("mem_wait", 0, 16'h4000, 0, 0, S_M, O_LD);
    end
    step_seq("mem_fault", 0, 16'h4000, 0, 1, S_X, O_FLT);
    step_seq("mem_fault_rst", 1, 16'h0000, 0, 0, S_X, O_FLT);
    step_seq("post_rst", 0, 16'h0000, 0, 0, S_F, O_FW);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
